// File: rtl/tinuc_mmio_pkg.sv
// Address map and timer control layout shared by the TinuC data-memory responder.
package tinuc_mmio_pkg;

    localparam logic [9:0] ADDR_LED   = 10'h200;
    localparam logic [9:0] ADDR_SW    = 10'h204;
    localparam logic [9:0] ADDR_CYCLE = 10'h208;
    localparam logic [9:0] ADDR_TCMP  = 10'h20C;
    localparam logic [9:0] ADDR_TCNT  = 10'h210;
    localparam logic [9:0] ADDR_TCTRL = 10'h214;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AR   = 1;
    localparam int TCTRL_FLAG = 2;

    // Member order places flag at bit 2 and en at bit 0, matching the register image.
    typedef struct packed {
        logic flag;
        logic autoreload;
        logic en;
    } tctrl_t;

endpackage

// File: rtl/tinuc_dmem_ram.sv
// Word-wide data RAM: combinational read, write on the rising edge, contents never reset.
module tinuc_dmem_ram #(
    parameter int RAM_WORDS = 128,
    parameter int IDX_W     = 7
) (
    input  logic             CLK,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/tinuc_dmem_responder.sv
// TinuC data-memory responder: RAM in the low half of the 1 KiB space, MMIO page
// (LEDs, synchronised switches, cycle counter, compare timer) in the high half.
module tinuc_dmem_responder
    import tinuc_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 128,
    parameter int LED_W     = 16,
    parameter int SW_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [9:0]       daddr,
    input  logic [31:0]      ddata_w,
    input  logic             d_rw,
    output logic [31:0]      ddata_r,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] leds,
    output logic             timer_irq
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_s1;
    logic [SW_W-1:0]  r_sw_s2;
    logic [31:0]      r_cycle;
    logic [31:0]      r_tcmp;
    logic [31:0]      r_tcnt;
    tctrl_t           r_tctrl;

    logic [9:0]       w_waddr;
    logic             w_ram_we;
    logic [31:0]      w_ram_rdata;
    logic             w_wr_led;
    logic             w_wr_cycle;
    logic             w_wr_tcmp;
    logic             w_wr_tcnt;
    logic             w_wr_tctrl;
    logic             w_match;
    logic [31:0]      w_tcnt_nxt;
    tctrl_t           w_tctrl_nxt;
    logic             w_unused_addr;

    assign w_waddr       = {daddr[9:2], 2'b00};
    assign w_unused_addr = ^daddr[1:0];

    // RESET also gates the RAM so a write in flight during reset is dropped.
    assign w_ram_we   = d_rw && !daddr[9] && !RESET;
    assign w_wr_led   = d_rw && (w_waddr == ADDR_LED);
    assign w_wr_cycle = d_rw && (w_waddr == ADDR_CYCLE);
    assign w_wr_tcmp  = d_rw && (w_waddr == ADDR_TCMP);
    assign w_wr_tcnt  = d_rw && (w_waddr == ADDR_TCNT);
    assign w_wr_tctrl = d_rw && (w_waddr == ADDR_TCTRL);

    tinuc_dmem_ram #(
        .RAM_WORDS (RAM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_ram_we),
        .i_idx   (daddr[2 +: IDX_W]),
        .i_wdata (ddata_w),
        .o_rdata (w_ram_rdata)
    );

    assign w_match = r_tctrl.en && (r_tcnt == r_tcmp);

    // Later assignments win: software TCNT/TCTRL writes override timer updates,
    // while a match in the same cycle keeps FLAG set against a W1C clear.
    always_comb begin
        w_tcnt_nxt  = r_tcnt;
        w_tctrl_nxt = r_tctrl;
        if (r_tctrl.en) begin
            if (w_match) begin
                w_tctrl_nxt.flag = 1'b1;
                if (r_tctrl.autoreload) begin
                    w_tcnt_nxt = '0;
                end else begin
                    w_tctrl_nxt.en = 1'b0;
                end
            end else begin
                w_tcnt_nxt = r_tcnt + 32'd1;
            end
        end
        if (w_wr_tcnt) begin
            w_tcnt_nxt = ddata_w;
        end
        if (w_wr_tctrl) begin
            w_tctrl_nxt.en         = ddata_w[TCTRL_EN];
            w_tctrl_nxt.autoreload = ddata_w[TCTRL_AR];
            if (ddata_w[TCTRL_FLAG] && !w_match) begin
                w_tctrl_nxt.flag = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_led   <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_cycle <= '0;
            r_tcmp  <= '0;
            r_tcnt  <= '0;
            r_tctrl <= '0;
        end else begin
            r_sw_s1 <= sw_in;
            r_sw_s2 <= r_sw_s1;
            r_cycle <= w_wr_cycle ? 32'd0 : r_cycle + 32'd1;
            r_tcnt  <= w_tcnt_nxt;
            r_tctrl <= w_tctrl_nxt;
            if (w_wr_led) begin
                r_led <= ddata_w[LED_W-1:0];
            end
            if (w_wr_tcmp) begin
                r_tcmp <= ddata_w;
            end
        end
    end

    always_comb begin
        ddata_r = '0;
        if (!daddr[9]) begin
            ddata_r = w_ram_rdata;
        end else begin
            case (w_waddr)
                ADDR_LED:   ddata_r = 32'(r_led);
                ADDR_SW:    ddata_r = 32'(r_sw_s2);
                ADDR_CYCLE: ddata_r = r_cycle;
                ADDR_TCMP:  ddata_r = r_tcmp;
                ADDR_TCNT:  ddata_r = r_tcnt;
                ADDR_TCTRL: ddata_r = {29'd0, r_tctrl};
                default:    ddata_r = '0;
            endcase
        end
    end

    assign leds      = r_led;
    assign timer_irq = r_tctrl.flag;

endmodule

// File: tb/tb_tinuc_dmem_responder.sv
// Directed bench for tinuc_dmem_responder: expected values queued with each stimulus, popped and compared on observation.
`timescale 1ns/1ps
module tb_tinuc_dmem_responder;

    logic        CLK;
    logic        RESET;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        d_rw;
    logic [31:0] ddata_r;
    logic [15:0] sw_in;
    logic [15:0] leds;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    localparam logic [9:0] A_LED   = 10'h200;
    localparam logic [9:0] A_SW    = 10'h204;
    localparam logic [9:0] A_CYCLE = 10'h208;
    localparam logic [9:0] A_TCMP  = 10'h20C;
    localparam logic [9:0] A_TCNT  = 10'h210;
    localparam logic [9:0] A_TCTRL = 10'h214;

    tinuc_dmem_responder #(
        .RAM_WORDS (128),
        .LED_W     (16),
        .SW_W      (16)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .daddr     (daddr),
        .ddata_w   (ddata_w),
        .d_rw      (d_rw),
        .ddata_r   (ddata_r),
        .sw_in     (sw_in),
        .leds      (leds),
        .timer_irq (timer_irq)
    );

    initial begin
        CLK = 1'b0;
        forever #50 CLK = ~CLK;
    end

    task automatic push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] e, input string tag);
        push(tag, e);
        daddr = a;
        d_rw  = 1'b0;
        #1;
        pop_cmp(ddata_r);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        daddr   = a;
        ddata_w = d;
        d_rw    = 1'b1;
        @(negedge CLK);
        d_rw    = 1'b0;
    endtask

    task automatic chk_leds(input logic [15:0] e, input string tag);
        push(tag, {16'd0, e});
        #1;
        pop_cmp({16'd0, leds});
    endtask

    task automatic chk_irq(input logic e, input string tag);
        push(tag, {31'd0, e});
        #1;
        pop_cmp({31'd0, timer_irq});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RESET   = 1'b1;
        daddr   = '0;
        ddata_w = '0;
        d_rw    = 1'b0;
        sw_in   = '0;
        idle(2);
        chk_leds(16'h0, "rst_leds");
        chk_irq(1'b0, "rst_irq");
        rd(A_TCTRL, 32'h0, "rst_tctrl");
        rd(A_TCNT,  32'h0, "rst_tcnt");
        rd(A_CYCLE, 32'h0, "rst_cycle");
        RESET = 1'b0;
        rd(A_CYCLE, 32'h0, "cycle_start");
        idle(3);
        rd(A_CYCLE, 32'd3, "cycle_count3");

        // RAM write/read, read-during-write returns old data
        wr(10'h010, 32'h11111111);
        rd(10'h010, 32'h11111111, "ram_first");
        daddr   = 10'h010;
        ddata_w = 32'hDEADBEEF;
        d_rw    = 1'b1;
        push("ram_rdw_old", 32'h11111111);
        #1;
        pop_cmp(ddata_r);
        @(negedge CLK);
        d_rw = 1'b0;
        rd(10'h010, 32'hDEADBEEF, "ram_new");
        rd(10'h013, 32'hDEADBEEF, "ram_byte_ignored");
        wr(10'h1FC, 32'hCAFEF00D);
        rd(10'h1FC, 32'hCAFEF00D, "ram_top");
        rd(10'h010, 32'hDEADBEEF, "ram_other_kept");

        // LEDs, switches, unmapped, cycle clear
        wr(A_LED, 32'h0000A5A5);
        chk_leds(16'hA5A5, "leds_a5a5");
        rd(A_LED, 32'h0000A5A5, "led_read");
        wr(A_LED, 32'hFFFFFFFF);
        rd(A_LED, 32'h0000FFFF, "led_zext");
        sw_in = 16'h1234;
        idle(1);
        rd(A_SW, 32'h0, "sw_one_cycle");
        idle(1);
        rd(A_SW, 32'h00001234, "sw_two_cycles");
        wr(A_SW, 32'h0);
        rd(A_SW, 32'h00001234, "sw_write_ignored");
        wr(10'h2F0, 32'h12345678);
        rd(10'h2F0, 32'h0, "unmapped_zero");
        wr(A_CYCLE, 32'h55);
        rd(A_CYCLE, 32'h0, "cycle_cleared");
        idle(2);
        rd(A_CYCLE, 32'd2, "cycle_after_clear");

        // Auto-reload timer, period 6
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'd0);
        wr(A_TCTRL, 32'h3);
        rd(A_TCNT, 32'd0, "ar_start");
        idle(5);
        rd(A_TCNT, 32'd5, "ar_at_cmp");
        chk_irq(1'b0, "ar_no_flag_yet");
        idle(1);
        chk_irq(1'b1, "ar_flag_rise");
        rd(A_TCNT, 32'd0, "ar_reload");
        wr(A_TCTRL, 32'h7);
        chk_irq(1'b0, "ar_w1c");
        rd(A_TCNT, 32'd1, "ar_count_on");
        idle(4);
        chk_irq(1'b0, "ar_period_pre");
        idle(1);
        chk_irq(1'b1, "ar_period_6");
        wr(A_TCTRL, 32'h4);
        rd(A_TCTRL, 32'h0, "ar_stopped");
        chk_irq(1'b0, "ar_irq_clear");

        // One-shot timer, software TCNT write beats increment
        wr(A_TCMP, 32'd3);
        wr(A_TCNT, 32'd0);
        wr(A_TCTRL, 32'h1);
        idle(1);
        wr(A_TCNT, 32'd0);
        rd(A_TCNT, 32'd0, "os_sw_load_wins");
        idle(3);
        rd(A_TCNT, 32'd3, "os_at_cmp");
        rd(A_TCTRL, 32'h1, "os_running");
        idle(1);
        rd(A_TCTRL, 32'h4, "os_en_cleared");
        rd(A_TCNT, 32'd3, "os_hold");
        chk_irq(1'b1, "os_irq");
        idle(2);
        rd(A_TCNT, 32'd3, "os_still_hold");
        wr(A_TCTRL, 32'h4);
        chk_irq(1'b0, "os_w1c");
        rd(A_TCTRL, 32'h0, "os_tctrl_zero");

        // Same-cycle priorities, then wrap
        wr(A_TCNT, 32'd0);
        wr(A_TCTRL, 32'h1);
        idle(3);
        wr(A_TCTRL, 32'h5);
        rd(A_TCTRL, 32'h5, "prio_flag_and_en");
        chk_irq(1'b1, "prio_irq");
        idle(1);
        rd(A_TCTRL, 32'h4, "prio_then_oneshot");
        wr(A_TCTRL, 32'h4);
        rd(A_TCTRL, 32'h0, "prio_cleared");
        wr(A_TCMP, 32'd1);
        wr(A_TCNT, 32'hFFFFFFFF);
        rd(A_TCNT, 32'hFFFFFFFF, "wrap_loaded");
        wr(A_TCTRL, 32'h1);
        rd(A_TCNT, 32'hFFFFFFFF, "wrap_en_edge");
        idle(1);
        rd(A_TCNT, 32'h0, "wrap_zero");
        idle(1);
        rd(A_TCNT, 32'h1, "wrap_one");
        chk_irq(1'b0, "wrap_no_flag");
        idle(1);
        chk_irq(1'b1, "wrap_flag");
        rd(A_TCTRL, 32'h4, "wrap_oneshot");

        // Reset in the middle of an LED write
        daddr   = A_LED;
        ddata_w = 32'h00005A5A;
        d_rw    = 1'b1;
        #2;
        RESET = 1'b1;
        chk_leds(16'h0, "rst_mid_leds");
        chk_irq(1'b0, "rst_mid_irq");
        rd(A_CYCLE, 32'h0, "rst_mid_cycle");
        rd(A_TCMP, 32'h0, "rst_mid_tcmp");
        @(negedge CLK);
        RESET = 1'b0;
        chk_leds(16'h0, "rst_write_lost");
        rd(A_LED, 32'h0, "rst_led_read");
        rd(A_CYCLE, 32'h0, "rst_cycle_zero");
        idle(1);
        rd(A_CYCLE, 32'd1, "rst_cycle_inc");
        rd(10'h010, 32'hDEADBEEF, "rst_ram_kept");
        rd(A_SW, 32'h0, "rst_sync_zero");
        idle(2);
        rd(A_SW, 32'h00001234, "rst_sync_resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
